serial_parity_rx: RTL and testbench

SERIAL_PARITY_RX -- requirements
Module: serial_parity_rx

---
 rtl/serial_parity_pkg.sv | 27 ++
 rtl/parity_acc.sv | 34 +++
 rtl/serial_parity_rx.sv | 133 +++++++++++++
 tb/tb_serial_parity_rx.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/serial_parity_pkg.sv
// ============================================================================
//  Module      : serial_parity_pkg
//  Description : Shared receive-FSM state encoding and parity-mode constants.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package serial_parity_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_e;

  localparam int unsigned PARITY_MODE_EVEN = 0;
  localparam int unsigned PARITY_MODE_ODD  = 1;

  // Counter must be able to hold DATA_W itself so it never wraps mid-frame.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/parity_acc.sv
// ============================================================================
//  Module      : parity_acc
//  Description : Running XOR parity bit with clear and enable.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_acc (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  input  logic bit_i,
  output logic acc_o
);

  logic acc_q;

  // Clear wins over enable so a start bit always opens a fresh accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= 1'b0;
    end else if (clr_i) begin
      acc_q <= 1'b0;
    end else if (en_i) begin
      acc_q <= acc_q ^ bit_i;
    end
  end

  assign acc_o = acc_q;

endmodule

`default_nettype wire

// File: rtl/serial_parity_rx.sv
// ============================================================================
//  Module      : serial_parity_rx
//  Description : Strobed serial receiver: start, DATA_W bits LSB first, parity, stop.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_parity_rx
  import serial_parity_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PARITY_ODD = PARITY_MODE_EVEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy
);

  localparam int unsigned          c_CNT_W = cnt_width(DATA_W);
  localparam logic [c_CNT_W-1:0]   c_LAST  = c_CNT_W'(DATA_W - 1);
  localparam logic                 c_ODD   = (PARITY_ODD != 0);

  state_e              state_q, state_d;
  logic [c_CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                perr_pend_q, perr_pend_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic                dvalid_q, dvalid_d;
  logic                perr_q, perr_d;
  logic                ferr_q, ferr_d;

  logic                w_acc;
  logic                w_acc_clr;
  logic                w_acc_en;

  parity_acc u_parity_acc (
    .clk   (clk),
    .rst   (rst),
    .clr_i (w_acc_clr),
    .en_i  (w_acc_en),
    .bit_i (bit_in),
    .acc_o (w_acc)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    perr_pend_d = perr_pend_q;
    dout_d      = dout_q;
    dvalid_d    = 1'b0;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    w_acc_clr   = 1'b0;
    w_acc_en    = 1'b0;

    if (bit_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (!bit_in) begin
            state_d   = ST_DATA;
            cnt_d     = '0;
            w_acc_clr = 1'b1;
          end
        end
        ST_DATA: begin
          for (int unsigned i = 0; i < DATA_W; i++) begin
            if (cnt_q == c_CNT_W'(i)) begin
              shift_d[i] = bit_in;
            end
          end
          w_acc_en = 1'b1;
          cnt_d    = cnt_q + c_CNT_W'(1);
          if (cnt_q == c_LAST) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          // Held until the stop bit so all status outputs update together.
          perr_pend_d = w_acc ^ bit_in ^ c_ODD;
          state_d     = ST_STOP;
        end
        ST_STOP: begin
          dout_d   = shift_q;
          perr_d   = perr_pend_q;
          ferr_d   = ~bit_in;
          dvalid_d = 1'b1;
          state_d  = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      perr_pend_q <= 1'b0;
      dout_q      <= '0;
      dvalid_q    <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      perr_pend_q <= perr_pend_d;
      dout_q      <= dout_d;
      dvalid_q    <= dvalid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
    end
  end

  assign data_out   = dout_q;
  assign data_valid = dvalid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_serial_parity_rx.sv
// ============================================================================
//  Module      : tb_serial_parity_rx
//  Description : Directed bench driving an even- and an odd-parity receiver in parallel.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_parity_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_in;
  logic       bit_valid;

  logic [7:0] dout_e, dout_o;
  logic       dv_e, dv_o, pe_e, pe_o, fe_e, fe_o, busy_e, busy_o;

  int checks   = 0;
  int errors   = 0;
  int pulses_e = 0;
  int pulses_o = 0;

  always #5 clk = ~clk;

  serial_parity_rx #(.DATA_W(8), .PARITY_ODD(0)) u_dut_even (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .data_out   (dout_e),
    .data_valid (dv_e),
    .parity_err (pe_e),
    .frame_err  (fe_e),
    .busy       (busy_e)
  );

  serial_parity_rx #(.DATA_W(8), .PARITY_ODD(1)) u_dut_odd (
    .clk        (clk),
    .rst        (rst),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .data_out   (dout_o),
    .data_valid (dv_o),
    .parity_err (pe_o),
    .frame_err  (fe_o),
    .busy       (busy_o)
  );

  always @(negedge clk) begin
    if (dv_e) pulses_e++;
    if (dv_o) pulses_o++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input int gap);
    bit_valid = 1'b0;
    repeat (gap) tick();
    bit_in    = b;
    bit_valid = 1'b1;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b1;
  endtask

  function automatic int rgap(input int maxgap);
    return (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
  endfunction

  // Start bit always goes out with no gap so back-to-back frames are exercised.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                            input int maxgap);
    send_bit(1'b0, 0);
    check("busy_mid_frame", {31'd0, busy_e}, 32'd1);
    for (int i = 0; i < 8; i++) send_bit(d[i], rgap(maxgap));
    send_bit(par, rgap(maxgap));
    send_bit(stop, rgap(maxgap));
  endtask

  task automatic check_frame(input string tag, input logic [7:0] d, input logic exp_pe_e,
                             input logic exp_pe_o, input logic exp_fe);
    check({tag, "_dv"},      {31'd0, dv_e},   32'd1);
    check({tag, "_dv_odd"},  {31'd0, dv_o},   32'd1);
    check({tag, "_data"},    {24'd0, dout_e}, {24'd0, d});
    check({tag, "_data_odd"},{24'd0, dout_o}, {24'd0, d});
    check({tag, "_perr"},    {31'd0, pe_e},   {31'd0, exp_pe_e});
    check({tag, "_perr_odd"},{31'd0, pe_o},   {31'd0, exp_pe_o});
    check({tag, "_ferr"},    {31'd0, fe_e},   {31'd0, exp_fe});
    check({tag, "_busy"},    {31'd0, busy_e}, 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    bit_in    = 1'b1;
    bit_valid = 1'b0;
    repeat (3) tick();
    check("rst_data",  {24'd0, dout_e}, 32'd0);
    check("rst_dv",    {31'd0, dv_e},   32'd0);
    check("rst_perr",  {31'd0, pe_e},   32'd0);
    check("rst_ferr",  {31'd0, fe_e},   32'd0);
    check("rst_busy",  {31'd0, busy_e}, 32'd0);
    rst = 1'b0;
    tick();

    // A one in IDLE is not a start bit.
    send_bit(1'b1, 0);
    check("idle_ignore_one", {31'd0, busy_e}, 32'd0);

    // 0xA5 has four ones: even parity bit 0.
    send_frame(8'hA5, 1'b0, 1'b1, 0);
    check_frame("a5_good", 8'hA5, 1'b0, 1'b1, 1'b0);
    tick();
    check("a5_dv_one_cycle", {31'd0, dv_e},   32'd0);
    check("a5_data_hold",    {24'd0, dout_e}, 32'h0000_00A5);
    check("pulses_1",        pulses_e,        32'd1);

    send_frame(8'hA5, 1'b1, 1'b1, 0);
    check_frame("a5_badpar", 8'hA5, 1'b1, 1'b0, 1'b0);
    tick();
    check("pulses_2", pulses_e, 32'd2);

    // 0x3C: correct even parity, stop bit 0.
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    check_frame("3c_frameerr", 8'h3C, 1'b0, 1'b1, 1'b1);
    tick();
    check("3c_stay_idle", {31'd0, busy_e}, 32'd0);
    check("pulses_3",     pulses_e,        32'd3);

    // Gapped frame, then an immediate back-to-back frame.
    send_frame(8'hA5, 1'b0, 1'b1, 5);
    check_frame("gap_a5", 8'hA5, 1'b0, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b0, 1'b1, 5);
    check_frame("b2b_5a", 8'h5A, 1'b0, 1'b1, 1'b0);
    tick();
    check("pulses_5",     pulses_e, 32'd5);
    check("pulses_odd_5", pulses_o, 32'd5);

    // Abort after the 4th data bit of 0x81 (LSB first: 1,0,0,0).
    send_bit(1'b0, 0);
    send_bit(1'b1, 0);
    send_bit(1'b0, 0);
    send_bit(1'b0, 0);
    send_bit(1'b0, 0);
    rst       = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b0;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b1;
    check("abort_busy", {31'd0, busy_e}, 32'd0);
    check("abort_dv",   {31'd0, dv_e},   32'd0);
    check("abort_data", {24'd0, dout_e}, 32'd0);
    rst = 1'b0;
    tick();
    send_frame(8'h81, 1'b0, 1'b1, 0);
    check_frame("after_abort_81", 8'h81, 1'b0, 1'b1, 1'b0);
    tick();
    check("pulses_6", pulses_e, 32'd6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
